// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM states and control encodings for the multicycle MIPS controller
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - state to datapath control word decoder; BNE_EN enables branch_ne in BNEEX
module mc_outdec
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   kill_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (!kill_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.alusrcb = SRCB_FOUR;
          ctrl_o.irwrite = mem_ready_i;
          ctrl_o.pcwrite = mem_ready_i;
        end
        S_DECODE:  ctrl_o.alusrcb = SRCB_IMMSH;
        S_MEMADR: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_IMM;
        end
        S_MEMRD:   ctrl_o.iord = 1'b1;
        S_MEMWB: begin
          ctrl_o.memtoreg = 1'b1;
          ctrl_o.regwrite = 1'b1;
        end
        // write strobe stays up until memory accepts it
        S_MEMWR: begin
          ctrl_o.iord     = 1'b1;
          ctrl_o.memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.aluop   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          ctrl_o.regdst   = 1'b1;
          ctrl_o.regwrite = 1'b1;
        end
        S_BEQEX: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.aluop   = ALUOP_SUB;
          ctrl_o.pcsrc   = PCSRC_ALUOUT;
          ctrl_o.branch  = 1'b1;
        end
        S_BNEEX: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.aluop   = ALUOP_SUB;
          ctrl_o.pcsrc   = PCSRC_ALUOUT;
`ifdef BNE_EN
          ctrl_o.branch_ne = 1'b1;
`endif
        end
        S_ADDIEX: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_IMM;
        end
        S_ADDIWB:  ctrl_o.regwrite = 1'b1;
        S_JEX: begin
          ctrl_o.pcsrc   = PCSRC_JUMP;
          ctrl_o.pcwrite = 1'b1;
        end
        default:   ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM with memory-ready stretching; BNE_EN adds bne
module mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_dec;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .kill_i      (reset),
    .ctrl_o      (ctrl)
  );

  // reset blanks every output, including the debug state view
  assign illegal_op = illegal_dec & ~reset;
  assign state_o    = reset ? '0 : STATE_W'(state_q);

  assign pcwrite   = ctrl.pcwrite;
  assign branch    = ctrl.branch;
  assign branch_ne = ctrl.branch_ne;
  assign iord      = ctrl.iord;
  assign memwrite  = ctrl.memwrite;
  assign irwrite   = ctrl.irwrite;
  assign regdst    = ctrl.regdst;
  assign memtoreg  = ctrl.memtoreg;
  assign regwrite  = ctrl.regwrite;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign pcsrc     = ctrl.pcsrc;
  assign aluop     = ctrl.aluop;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller, random instruction streams; honours BNE_EN
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, branch, branch_ne, iord, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .illegal_op(illegal_op), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcwrite, branch, branch_ne, iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_cyc = 0;

`ifdef BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  // Expected outputs straight from the per-state output table
  function automatic obs_t model(input int st, input bit mr, input bit rst, input bit ill);
    obs_t o;
    o = '0;
    if (rst) return o;
    o.st = 4'(st);
    case (st)
      0:  begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      1:  begin o.alusrcb = 2'b11; o.illegal = ill; end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.memtoreg = 1; o.regwrite = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1;
      11: begin o.pcsrc = 2'b10; o.pcwrite = 1; end
      12: begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch_ne = BNE_ON; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic cyc(input bit rst, input logic [5:0] o, input bit mr, input int st, input bit ill);
    @(posedge clk);
    #1;
    reset = rst;
    op = o;
    mem_ready = mr;
    exp_q.push_back(model(st, mr, rst, ill));
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  // One instruction as a list of steps: FETCH (with waits), DECODE, then the op's execute path
  task automatic run_instr(input logic [5:0] iop, input int wf, input int wm);
    for (int i = 0; i < wf; i++) cyc(0, rop(), 0, 0, 0);
    cyc(0, rop(), 1, 0, 0);
    case (iop)
      6'b100011: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, iop, rbit(), 2, 0);
        for (int i = 0; i < wm; i++) cyc(0, rop(), 0, 3, 0);
        cyc(0, rop(), 1, 3, 0);
        cyc(0, rop(), rbit(), 4, 0);
      end
      6'b101011: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, iop, rbit(), 2, 0);
        for (int i = 0; i < wm; i++) cyc(0, rop(), 0, 5, 0);
        cyc(0, rop(), 1, 5, 0);
      end
      6'b000000: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, rop(), rbit(), 6, 0);
        cyc(0, rop(), rbit(), 7, 0);
      end
      6'b001000: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, rop(), rbit(), 9, 0);
        cyc(0, rop(), rbit(), 10, 0);
      end
      6'b000100: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, rop(), rbit(), 8, 0);
      end
      6'b000010: begin
        cyc(0, iop, rbit(), 1, 0);
        cyc(0, rop(), rbit(), 11, 0);
      end
      6'b000101: begin
        if (BNE_ON) begin
          cyc(0, iop, rbit(), 1, 0);
          cyc(0, rop(), rbit(), 12, 0);
        end else begin
          cyc(0, iop, rbit(), 1, 1);
        end
      end
      default: cyc(0, iop, rbit(), 1, 1);
    endcase
  endtask

  always @(negedge clk) begin
    obs_t got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = '{st: state_o, pcwrite: pcwrite, branch: branch, branch_ne: branch_ne,
              iord: iord, memwrite: memwrite, irwrite: irwrite, regdst: regdst,
              memtoreg: memtoreg, regwrite: regwrite, alusrca: alusrca,
              alusrcb: alusrcb, pcsrc: pcsrc, aluop: aluop, illegal: illegal_op};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ctrl cycle %0d: got st=%0d word=%h, expected st=%0d word=%h",
                 n_cyc, got.st, got, exp.st, exp);
      end
      n_cyc++;
    end
  end

  initial begin
    logic [5:0] ops [8];
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000101; ops[7] = 6'b111111;

    cyc(1, 6'd0, 0, 0, 0);
    cyc(1, 6'd0, 1, 0, 0);

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b000000, 1, 0);
    run_instr(6'b001000, 0, 0);

    // reset arrives while lw waits in MEMRD
    cyc(0, rop(), 1, 0, 0);
    cyc(0, 6'b100011, 1, 1, 0);
    cyc(0, 6'b100011, 1, 2, 0);
    cyc(0, rop(), 0, 3, 0);
    cyc(1, rop(), 1, 0, 0);
    cyc(1, rop(), 1, 0, 0);
    run_instr(6'b100011, 0, 1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] iop;
      iop = ops[$urandom_range(0, 7)];
      if (iop == 6'b111111) iop = rop();
      run_instr(iop, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle MIPS control unit: a Moore FSM that sequences the shared multicycle datapath (single memory, single ALU, IR, PC) through fetch/decode/execute/writeback steps.
Emits per-cycle datapath enables and mux selects, decoded from the latched opcode.
Supports a memory-ready handshake so fetch, load and store stretch over slow memory.
Sits beside the ALU decoder, which consumes aluop.

Parameters:
STATE_W, 4, width of state register and state_o debug port (minimum 4).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
op  in  6  opcode field from the instruction register.
mem_ready  in  1  memory completes the current access this cycle.
pcwrite  out  1  unconditional PC write enable.
branch  out  1  PC write enable, qualified by ALU zero in the datapath.
branch_ne  out  1  PC write enable, qualified by ALU !zero; tied 0 unless BNE_EN.
iord  out  1  memory address select: 0=PC, 1=ALUOut.
memwrite  out  1  memory write strobe.
irwrite  out  1  instruction register load enable.
regdst  out  1  write register select: 0=rt, 1=rd.
memtoreg  out  1  writeback select: 0=ALUOut, 1=MDR.
regwrite  out  1  register file write enable.
alusrca  out  1  ALU A select: 0=PC, 1=regA.
alusrcb  out  2  ALU B select: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
aluop  out  2  00=add, 01=sub, 10=use funct.
illegal_op  out  1  one-cycle pulse on an unsupported opcode in DECODE.
state_o  out  STATE_W  current state encoding, for debug.

Behaviour:
- State encoding (decimal): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
- Reset: a synchronous reset on any cycle, including mid-instruction or mid-wait, forces FETCH next edge. In-flight work is dropped.
- Output values per state. Every output not listed is 0; this includes all outputs during the reset cycle.
  - FETCH: alusrcb=01; irwrite=pcwrite=mem_ready (combinational).
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1; memwrite is held until mem_ready.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNEEX: as BEQEX, but branch_ne=1 instead of branch.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH: to DECODE if mem_ready, else stay.
  - DECODE by op:
    - 100011 or 101011 -> MEMADR.
    - 000000 -> RTYPEEX.
    - 000100 -> BEQEX.
    - 001000 -> ADDIEX.
    - 000010 -> JEX.
    - 000101 -> BNEEX (with BNE_EN only).
    - any other opcode -> FETCH with illegal_op=1.
  - MEMADR: to MEMRD if op=100011, else MEMWR.
  - MEMRD: to MEMWB if mem_ready, else stay.
  - MEMWR: to FETCH if mem_ready, else stay.
  - RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX -> FETCH.
- Latency with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- op is sampled only in DECODE and MEMADR. The IR is stable after FETCH, so op changes in other states have no effect.
- Unused state codes go to FETCH, with all outputs 0.

Optional Feature:
BNE_EN:
- Defined: op 000101 decodes to BNEEX; branch_ne is driven as specified above.
- Undefined: BNEEX is unreachable, branch_ne is constant 0, and 000101 is illegal (illegal_op pulse, back to FETCH).

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - the state enum typedef;
  - aluop, alusrcb and pcsrc encodings.
- Sub-module mc_outdec: combinational state-to-control-word decoder, instantiated by the FSM.

Test Plan:
- Reset held 2 cycles mid-MEMRD, mem_ready=1 -> state_o=0 next edge; all outputs 0 during reset.
- lw (op=100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- sw (op=101011), mem_ready low 3 cycles in MEMWR -> memwrite and iord held high 4 cycles; then FETCH.
- beq (op=000100) -> sequence 0,1,8,0; in state 8: branch=1, aluop=01, pcsrc=01.
- j (op=000010) -> 0,1,11,0 with pcwrite=1 and pcsrc=10 in state 11. op=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH.
- op=000101 -> with BNE_EN: 0,1,12,0 and branch_ne=1 in state 12; without it: illegal_op=1 and return to FETCH.
